// File: rtl/ritc_user_bus_master.sv
// ritc_user_bus_master: single-outstanding initiator for the RITC datapath
// register bus. One host command becomes one registered bus strobe; reads
// capture slave data a fixed RD_LATENCY after the strobe and return it on
// a valid/ready response port.
// Optional build macro RITC_BUS_READBACK_EN: every write is followed by an
// idle cycle and a read of the same address, and the response reports the
// read-back data plus a mismatch flag.
module ritc_user_bus_master #(
  parameter int RD_LATENCY = 2,  // 1..15
  parameter int GAP        = 1   // 0..7
) (
  input  logic        user_clk_i,
  input  logic        user_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wr_i,
  input  logic [3:0]  cmd_addr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        user_sel_o,
  output logic [3:0]  user_addr_o,
  output logic        user_wr_o,
  output logic        user_rd_o,
  output logic [31:0] user_dat_o,
  input  logic [31:0] user_dat_i
);

  localparam logic [3:0] LAT_C = 4'(RD_LATENCY);
  localparam logic [3:0] GAP_C = 4'(GAP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_GAPW  = 3'd4
`ifdef RITC_BUS_READBACK_EN
    , S_RBGAP    = 3'd5,
    S_READBACK = 3'd6
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic [3:0]  cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_dat_q, cmd_dat_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        sel_q, sel_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] udat_q, udat_d;
  logic        drive_bus, rd_strobe;

  // Next state plus next values of every registered output (decoded from
  // state_d so the pins change cleanly on the clock edge that enters a state).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_dat_d  = cmd_dat_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: if (cmd_valid_i && cmd_ready_q) begin
        cmd_wr_d   = cmd_wr_i;
        cmd_addr_d = cmd_addr_i;
        cmd_dat_d  = cmd_dat_i;
        state_d    = S_ISSUE;
      end
      S_ISSUE: if (cmd_wr_q) begin
`ifdef RITC_BUS_READBACK_EN
        state_d   = S_RBGAP;
`else
        rsp_dat_d = '0;
        rsp_err_d = 1'b0;
        state_d   = S_RESP;
`endif
      end else begin
        cnt_d   = LAT_C;
        state_d = S_WAIT;
      end
`ifdef RITC_BUS_READBACK_EN
      S_RBGAP:    state_d = S_READBACK;
      S_READBACK: begin
        cnt_d   = LAT_C;
        state_d = S_WAIT;
      end
`endif
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          rsp_dat_d = user_dat_i;
`ifdef RITC_BUS_READBACK_EN
          rsp_err_d = cmd_wr_q && (user_dat_i != cmd_dat_q);
`else
          rsp_err_d = 1'b0;
`endif
          state_d   = S_RESP;
        end
      end
      S_RESP: if (rsp_ready_i) begin
        if (GAP == 0) state_d = S_IDLE;
        else begin
          cnt_d   = GAP_C;
          state_d = S_GAPW;
        end
      end
      S_GAPW: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rd_strobe = (state_d == S_ISSUE) && !cmd_wr_d;
    drive_bus = (state_d == S_ISSUE) || (state_d == S_WAIT);
`ifdef RITC_BUS_READBACK_EN
    rd_strobe = rd_strobe || (state_d == S_READBACK);
    drive_bus = drive_bus || (state_d == S_RBGAP) || (state_d == S_READBACK);
`endif
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    wr_d        = (state_d == S_ISSUE) && cmd_wr_d;
    rd_d        = rd_strobe;
    sel_d       = wr_d || rd_d;
    addr_d      = drive_bus ? cmd_addr_d : 4'd0;
    udat_d      = drive_bus ? cmd_dat_d : 32'd0;
  end

  // State and output registers; reset drops strobes and discards any command.
  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_dat_q   <= '0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      udat_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_dat_q   <= cmd_dat_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      udat_q      <= udat_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != S_IDLE);
  assign user_sel_o  = sel_q;
  assign user_wr_o   = wr_q;
  assign user_rd_o   = rd_q;
  assign user_addr_o = addr_q;
  assign user_dat_o  = udat_q;

endmodule

// File: tb/tb_ritc_user_bus_master.sv
// Directed bench for ritc_user_bus_master (RD_LATENCY=2, GAP=1).
// A slave model returns its data only in the cycle RD_LATENCY after a read
// strobe; any other cycle carries a poison pattern.
module tb_ritc_user_bus_master;
  localparam int RD_L = 2;
  localparam int GP   = 1;
`ifdef RITC_BUS_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        sel, bwr, brd;
  logic [3:0]  baddr;
  logic [31:0] bdat_o, bdat_i;
  logic [31:0] slave_val;
  logic [15:0] rd_pipe;

  int checks   = 0;
  int failures = 0;

  ritc_user_bus_master #(.RD_LATENCY(RD_L), .GAP(GP)) dut (
    .user_clk_i(clk), .user_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .user_sel_o(sel), .user_addr_o(baddr), .user_wr_o(bwr), .user_rd_o(brd),
    .user_dat_o(bdat_o), .user_dat_i(bdat_i)
  );

  always #5 clk = ~clk;

  // slave: data valid only RD_L cycles after the read strobe cycle
  always @(posedge clk) rd_pipe <= {rd_pipe[14:0], brd};
  assign bdat_i = rd_pipe[RD_L-1] ? slave_val : 32'hBAD0_BAD0;

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] dat;
    logic [31:0] slave;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic w, input logic [3:0] a,
                              input logic [31:0] d, input logic [31:0] s);
    vec_t v;
    v.wr = w; v.addr = a; v.dat = d; v.slave = s;
    v.exp_dat = w ? (RB ? s : 32'd0) : s;
    v.exp_err = w && RB && (s != d);
    return v;
  endfunction

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!cmd_ready && n < 30) begin @(negedge clk); n++; end
    if (!cmd_ready) chk({nm, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
  endtask

  // One command with rsp_ready held high; checks every cycle from issue to
  // the return of cmd_ready after the gap.
  task automatic run_cmd(input int idx, input vec_t v);
    string p;
    int lat;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_dat = v.dat;
    slave_val = v.slave; rsp_ready = 1'b1;
    wait_ready(p);
    @(negedge clk);  // T+1
    cmd_valid = 1'b0;
    chk({p, "_sel"},   32'(sel),   32'd1);
    chk({p, "_wr"},    32'(bwr),   32'(v.wr));
    chk({p, "_rd"},    32'(brd),   32'(!v.wr));
    chk({p, "_addr"},  32'(baddr), 32'(v.addr));
    chk({p, "_bdat"},  bdat_o,     v.dat);
    chk({p, "_ready"}, 32'(cmd_ready), 32'd0);
    lat = v.wr ? (RB ? 3 + RD_L : 1) : 1 + RD_L;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk({p, $sformatf("_early_rsp%0d", i)}, 32'(rsp_valid), 32'd0);
      if (v.wr && RB && i == 1) chk({p, "_rb_gap_sel"}, 32'(sel), 32'd0);
      else if (v.wr && RB && i == 2) begin
        chk({p, "_rb_rd"},   32'(brd),   32'd1);
        chk({p, "_rb_addr"}, 32'(baddr), 32'(v.addr));
      end else chk({p, $sformatf("_sel_idle%0d", i)}, 32'(sel), 32'd0);
    end
    @(negedge clk);  // H: response cycle
    chk({p, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({p, "_rsp_dat"},   rsp_dat,        v.exp_dat);
    chk({p, "_rsp_err"},   32'(rsp_err),   32'(v.exp_err));
    chk({p, "_rsp_addr0"}, 32'(baddr),     32'd0);
    @(negedge clk);  // H+1
    chk({p, "_rsp_drop"},  32'(rsp_valid), 32'd0);
    chk({p, "_gap_ready"}, 32'(cmd_ready), 32'd0);
    @(negedge clk);  // H+2
    chk({p, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_dat = '0;
    rsp_ready = 1'b0; slave_val = '0;
    vecs[0] = mk(1'b1, 4'h2, 32'h0000_001F, 32'h0000_001F);
    vecs[1] = mk(1'b0, 4'h1, 32'h0,         32'hA5A5_0003);
    vecs[2] = mk(1'b1, 4'h3, 32'hFFFF_FFFF, 32'h0000_0000);
    vecs[3] = mk(1'b0, 4'h0, 32'h0,         32'h0000_0000);
    vecs[4] = mk(1'b0, 4'hF, 32'h0,         32'hFFFF_FFFF);
    vecs[5] = mk(1'b1, 4'h0, 32'h0000_0001, 32'h0000_0000);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_rspv",  32'(rsp_valid), 32'd0);
    chk("rst_rspd",  rsp_dat,        32'd0);
    chk("rst_err",   32'(rsp_err),   32'd0);
    chk("rst_sel",   32'(sel),       32'd0);
    chk("rst_wr",    32'(bwr),       32'd0);
    chk("rst_rd",    32'(brd),       32'd0);
    chk("rst_addr",  32'(baddr),     32'd0);
    chk("rst_bdat",  bdat_o,         32'd0);
    rst_n = 1'b1;
    #1 chk("rel_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("rel_ready_high", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_cmd(i, vecs[i]);

    // back-pressure on a read response; cmd_valid stays high meanwhile
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'h1; slave_val = 32'h1234_5678;
    rsp_ready = 1'b0;
    wait_ready("bp");
    @(negedge clk);
    cmd_wr = 1'b1; cmd_addr = 4'h5; cmd_dat = 32'hCAFE_0000;
    n = 0;
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    chk("bp_rsp_arrived", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_dat%0d", k),   rsp_dat,        32'h1234_5678);
      chk($sformatf("bp_ready%0d", k), 32'(cmd_ready), 32'd0);
      chk($sformatf("bp_sel%0d", k),   32'(sel),       32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_drop",   32'(rsp_valid), 32'd0);
    chk("bp_gap",    32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("bp_ready2", 32'(cmd_ready), 32'd1);

    // reset asserted while a read waits for its data
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'h3; slave_val = 32'h0F0F_0F0F;
    wait_ready("rw");
    @(negedge clk);  // ISSUE
    cmd_valid = 1'b0;
    @(negedge clk);  // WAIT
    chk("rw_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_sel",   32'(sel),       32'd0);
    chk("rw_rd",    32'(brd),       32'd0);
    chk("rw_rspv",  32'(rsp_valid), 32'd0);
    chk("rw_busy0", 32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen = seen | rsp_valid | sel;
    end
    chk("rw_no_rsp", 32'(seen), 32'd0);
    chk("rw_ready",  32'(cmd_ready), 32'd1);

    // the bus still works after the aborted read
    run_cmd(9, vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
